// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: instruction-fetch front end with a DEPTH-entry
// prefetch queue between instruction memory and decode.
// Optional self-modifying-code store snoop: define FETCH_SMC_SNOOP_EN.
//
// Handshakes:
//  - imem: a request is accepted, and imem_rdata is valid, in any cycle
//    with imem_req && !imem_wait. imem_addr is held while imem_wait is high.
//    A request may be withdrawn while imem_wait is high (redirect/snoop).
//  - decode: the head entry transfers in any cycle with if_valid && if_ready.
//    if_ready is ignored while if_valid is low.
module fetch_prefetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_wait,
  input  logic [31:0]                imem_rdata,
  output logic                       if_valid,
  output logic [31:0]                if_instr,
  output logic [XLEN-1:0]            if_pc,
  input  logic                       if_ready,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       store_valid,
  input  logic [XLEN-1:0]            store_addr,
  input  logic [1:0]                 store_size,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic            accept;
  logic            push;
  logic            pop;
  logic            snoop_flush;
  logic            head_hit;
  logic            fetch_hit;
  logic [CW-1:0]   flush_idx;
  logic [XLEN-1:0] flush_pc;

  // Redirect targets are forced word aligned, so the low bits are dropped.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

`ifdef FETCH_SMC_SNOOP_EN
  logic [XLEN-1:0] store_end;
  logic            unused_store_end_bits;

  // Last byte touched by the store; a store hits a word if either end lands in it.
  always_comb begin
    store_end = store_addr;
    case (store_size)
      2'b00:   store_end = store_addr;
      2'b01:   store_end = store_addr + XLEN'(1);
      default: store_end = store_addr + XLEN'(3);
    endcase
  end
  assign unused_store_end_bits = ^store_end[1:0];

  function automatic logic word_hit(input logic [XLEN-1:0] pc,
                                    input logic [XLEN-1:0] lo,
                                    input logic [XLEN-1:0] hi,
                                    input logic            sv);
    return sv && ((lo[XLEN-1:2] == pc[XLEN-1:2]) || (hi[XLEN-1:2] == pc[XLEN-1:2]));
  endfunction

  // Find the oldest queued entry hit by the store (scan youngest to oldest).
  always_comb begin
    snoop_flush = 1'b0;
    flush_idx   = '0;
    flush_pc    = fetch_pc;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if ((CW'(k) < count) &&
          word_hit(pc_mem[rd_ptr + PW'(k)], store_addr, store_end, store_valid)) begin
        snoop_flush = 1'b1;
        flush_idx   = CW'(k);
        flush_pc    = pc_mem[rd_ptr + PW'(k)];
      end
    end
  end

  assign head_hit  = snoop_flush && (flush_idx == '0);
  assign fetch_hit = imem_req && word_hit(fetch_pc, store_addr, store_end, store_valid);
`else
  logic unused_store;
  assign unused_store = ^{store_valid, store_addr, store_size};
  assign snoop_flush  = 1'b0;
  assign head_hit     = 1'b0;
  assign fetch_hit    = 1'b0;
  assign flush_idx    = '0;
  assign flush_pc     = fetch_pc;
`endif

  assign imem_addr = fetch_pc;
  assign imem_req  = rst && (count < CW'(DEPTH)) && !redirect && !snoop_flush;
  assign accept    = imem_req && !imem_wait;
  // An in-flight fetch overwritten by a store is dropped and reissued.
  assign push      = accept && !fetch_hit;
  assign if_valid  = (count != '0) && !head_hit;
  assign pop       = if_valid && if_ready;
  assign if_pc     = if_valid ? pc_mem[rd_ptr]    : '0;
  assign if_instr  = if_valid ? instr_mem[rd_ptr] : '0;
  assign q_count   = count;

  // Queue storage: write the accepted word at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

  // Fetch PC, pointers and occupancy; redirect beats snoop beats normal flow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (snoop_flush) begin
      fetch_pc <= flush_pc;
      wr_ptr   <= rd_ptr + flush_idx[PW-1:0];
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count    <= flush_idx - CW'(pop);
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
Parametrised instruction-fetch front end for the pipelined RISC-V core. It replaces the single-entry fetch/decode register with a DEPTH-entry prefetch queue. It keeps one instruction-memory request in flight under the wait handshake and flushes on branch/jump redirect. Optionally, it snoops data-memory stores and refetches overwritten instructions (self-modifying code).

Parameters:
XLEN, 32, address/PC width
DEPTH, 4, queue entries; power of two, >=2
RESET_PC, 0, fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address (word aligned)
imem_wait  in  1  memory busy; request accepted and imem_rdata valid in any cycle with imem_req && !imem_wait
imem_rdata  in  32  fetched instruction word
if_valid  out  1  head entry valid to decode
if_instr  out  32  head instruction
if_pc  out  XLEN  head PC
if_ready  in  1  decode consumes head this cycle
redirect  in  1  branch/jump taken; flush
redirect_pc  in  XLEN  new fetch address
store_valid  in  1  data store retiring this cycle
store_addr  in  XLEN  store byte address
store_size  in  2  00 byte, 01 half, 10 word
q_count  out  clog2(DEPTH)+1  valid entries

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, queue empty, q_count=0, if_valid=0, if_instr=0, if_pc=0, imem_req=0, imem_addr=RESET_PC.
- imem_addr = fetch_pc.
- imem_req = (q_count<DEPTH) && !redirect && !snoop_flush.
- Address is stable while imem_wait is high: fetch_pc changes only on accept, redirect or snoop_flush.
- accept = imem_req && !imem_wait. On accept, push {fetch_pc, imem_rdata} at the tail and set fetch_pc += 4 (mod 2^XLEN).
- if_valid = (q_count!=0) && !head_hit. if_instr and if_pc come from the head entry; otherwise 0.
- pop = if_valid && if_ready.
- Latency: data accepted in cycle N appears on if_* in N+1. No combinational bypass.
- Push and pop in the same cycle: q_count unchanged.
- Full queue: imem_req low, so no push; a pop frees a slot and imem_req rises in the next cycle.
- Empty queue: if_valid low and if_ready ignored.
- Read/write pointers wrap modulo DEPTH.
- Redirect (highest priority):
  - Queue cleared and q_count=0 next cycle.
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - Any same-cycle accept or pop is discarded.
  - The new request is issued the cycle after redirect.
- imem may see a request withdrawn while imem_wait is high (redirect/snoop). The memory tolerates this, and its late response is never sampled because imem_req is low.
- q_count is always <= DEPTH.

Optional Feature:
Macro FETCH_SMC_SNOOP_EN.
- Enabled:
  - A store covers bytes store_addr .. store_addr+nbytes-1, where nbytes is 1, 2 or 4.
  - It hits entry e if either endpoint's [XLEN-1:2] equals e.pc[XLEN-1:2]. The same test applies to fetch_pc when imem_req is high.
  - If any queued entry hits: the oldest hitting entry and all younger entries are dropped, and fetch_pc = that entry's pc. This is snoop_flush.
  - head_hit suppresses if_valid and pop in that cycle.
  - If only the in-flight fetch hits: that cycle's accept is discarded and fetch_pc is unchanged (refetch).
  - redirect overrides snoop.
- Disabled: store_* ports are unused; snoop_flush=0 and head_hit=0.

Test Plan:
- Reset, then imem_wait=0 and if_ready=0: addresses 0,4,8,12 accepted in consecutive cycles; q_count reaches 4; imem_req drops; if_pc=0.
- imem_wait=1 for 3 cycles at addr 0x10: imem_req and imem_addr=0x10 held constant; push occurs only on the first !imem_wait cycle.
- Full queue, if_ready=1 continuously with imem_wait=0: one pop and one push per cycle in steady state; PCs delivered strictly +4 with no gaps or duplicates.
- redirect=1 with redirect_pc=0x203 while accept and pop occur: next cycle q_count=0 and imem_addr=0x200; the discarded word never appears; first if_pc=0x200 two cycles later.
- FETCH_SMC_SNOOP_EN, queue holds PCs 0x40..0x4C: word store to 0x46 (hits 0x44 and 0x48) → entries 0x44..0x4C dropped, q_count=1, next imem_addr=0x44; re-fetched data delivered.
- Reset asserted mid-wait with q_count=3: outputs return to reset values immediately; after release, fetch restarts at RESET_PC.
